// File: rtl/add_pipe_seg_pkg.sv
// Shared adder definitions: op encodings and stage-count helpers for add_pipe_seg.
// The ADD_PIPE_FLAGS_EN macro (cout/ovf flags) is consumed by the files that import this package.
package adder_pkg;

    localparam logic ADD_OP_ADD = 1'b0;
    localparam logic ADD_OP_SUB = 1'b1;

    function automatic int seg_cnt(input int dataLen, input int segLen);
        return (dataLen + segLen - 1) / segLen;
    endfunction

    // The top slice absorbs whatever is left over, so it may be narrower than segLen.
    function automatic int seg_width(input int dataLen, input int segLen, input int idx);
        int low;
        low = idx * segLen;
        return ((dataLen - low) < segLen) ? (dataLen - low) : segLen;
    endfunction

endpackage

// File: rtl/add_pipe_seg_if.sv
// Valid/ready bus for add_pipe_seg; cout/ovf exist only when ADD_PIPE_FLAGS_EN is defined.
interface add_pipe_seg_if #(
    parameter int DATA_LEN = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] op_a;
    logic [DATA_LEN-1:0] op_b;
    logic                op_sub;
    logic                cin;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] sum;

`ifdef ADD_PIPE_FLAGS_EN
    logic                cout;
    logic                ovf;

    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, sum
    );
`endif

endinterface

// File: rtl/add_pipe_seg_stage.sv
// One slice of the segmented adder: adds bits [LO +: W] and holds the op in a valid/ready register.
// With ADD_PIPE_FLAGS_EN defined, the LAST stage also registers the signed-overflow flag.
module add_pipe_stage
    import adder_pkg::*;
#(
    parameter int DATA_LEN = 64,
    parameter int LO       = 0,
    parameter int W        = 16,
    parameter bit LAST     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_LEN-1:0] i_x,
    input  logic [DATA_LEN-1:0] i_b,
    input  logic                i_carry,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_LEN-1:0] o_x,
    output logic [DATA_LEN-1:0] o_b,
`ifdef ADD_PIPE_FLAGS_EN
    output logic                o_ovf,
`endif
    output logic                o_carry
);

    localparam int HI = LO + W;
    // i_x holds finished result bits below LO and untouched A above; B' is only carried where still needed.
    localparam logic [DATA_LEN-1:0] KEEP_MASK = {DATA_LEN{1'b1}} << HI;

    logic [W:0]          w_slice;
    logic [DATA_LEN-1:0] w_x;

    logic                r_valid;
    logic [DATA_LEN-1:0] r_x;
    logic [DATA_LEN-1:0] r_b;
    logic                r_carry;

    assign w_slice = {1'b0, i_x[LO +: W]} + {1'b0, i_b[LO +: W]} + {{W{1'b0}}, i_carry};

    always_comb begin
        w_x           = i_x;
        w_x[LO +: W]  = w_slice[W-1:0];
    end

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_b     = r_b;
    assign o_carry = r_carry;

`ifdef ADD_PIPE_FLAGS_EN
    logic w_ovf;
    logic r_ovf;

    // i_x[HI-1] is still the original A MSB here because this slice has not been written yet.
    assign w_ovf = LAST && (i_x[HI-1] == i_b[HI-1]) && (w_slice[W-1] != i_x[HI-1]);
    assign o_ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
`ifdef ADD_PIPE_FLAGS_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (o_ready) begin
                r_valid <= i_valid;
            end
            if (i_valid && o_ready) begin
                r_x     <= w_x;
                r_b     <= i_b & KEEP_MASK;
                r_carry <= w_slice[W];
`ifdef ADD_PIPE_FLAGS_EN
                r_ovf   <= w_ovf;
`endif
            end
        end
    end

endmodule

// File: rtl/add_pipe_seg.sv
// Segmented, pipelined adder/subtractor: one SEG_LEN slice per stage, carry registered between stages.
// Define ADD_PIPE_FLAGS_EN to add the pipelined cout and ovf outputs.
module add_pipe_seg
    import adder_pkg::*;
#(
    parameter int DATA_LEN = 64,
    parameter int SEG_LEN  = 16
) (
    input  logic          clk,
    input  logic          rst,
    add_pipe_seg_if.slave bus
);

    localparam int STAGES = seg_cnt(DATA_LEN, SEG_LEN);

    logic                w_valid [0:STAGES];
    logic                w_ready [0:STAGES];
    logic [DATA_LEN-1:0] w_x     [0:STAGES];
    logic [DATA_LEN-1:0] w_b     [0:STAGES];
    logic                w_carry [0:STAGES];

    // Subtraction reuses the adder: A - B - borrow == A + ~B + ~borrow.
    assign w_valid[0] = bus.in_valid;
    assign w_x[0]     = bus.op_a;
    assign w_b[0]     = (bus.op_sub == ADD_OP_SUB) ? ~bus.op_b : bus.op_b;
    assign w_carry[0] = (bus.op_sub == ADD_OP_SUB) ? ~bus.cin  : bus.cin;

    assign bus.in_ready     = w_ready[0];
    assign w_ready[STAGES]  = bus.out_ready;
    assign bus.out_valid    = w_valid[STAGES];
    assign bus.sum          = w_x[STAGES];

`ifdef ADD_PIPE_FLAGS_EN
    logic w_ovf [0:STAGES];

    assign w_ovf[0] = 1'b0;
    assign bus.cout = w_carry[STAGES];
    assign bus.ovf  = w_ovf[STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_pipe_stage #(
            .DATA_LEN (DATA_LEN),
            .LO       (k * SEG_LEN),
            .W        (seg_width(DATA_LEN, SEG_LEN, k)),
            .LAST     (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_x     (w_x[k]),
            .i_b     (w_b[k]),
            .i_carry (w_carry[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_x     (w_x[k+1]),
            .o_b     (w_b[k+1]),
`ifdef ADD_PIPE_FLAGS_EN
            .o_ovf   (w_ovf[k+1]),
`endif
            .o_carry (w_carry[k+1])
        );
    end

endmodule
